// File: rtl/operand_fetch_pkg.sv
// rtl/operand_fetch_pkg.sv - shared constants, ALU opcodes and operand bundle for operand_fetch
package operand_fetch_pkg;

  localparam int DW   = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  // SLT is any opcode with bit 2 set; 3'b100 is the canonical encoding.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [2:0]    ctrl;
    logic [AW-1:0] dest;
  } operand_t;

  function automatic logic [DW-1:0] sext16(input logic [15:0] imm);
    return {{(DW-16){imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/operand_fetch_reg_file.sv
// rtl/operand_fetch_reg_file.sv - 2R/1W register file, $0 hardwired to zero
// REGFILE_BYPASS_EN: same-cycle write data is forwarded to matching read ports.
module operand_fetch_reg_file
  import operand_fetch_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rd_a_addr,
  output logic [DW-1:0] rd_a_data,
  input  logic [AW-1:0] rd_b_addr,
  output logic [DW-1:0] rd_b_data,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data
);

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic          wr_hit;

  assign wr_hit = wb_en && (wb_addr != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_hit) regs_d[wb_addr] = wb_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd_a_data = (rd_a_addr == '0) ? '0 : regs_q[rd_a_addr];
    rd_b_data = (rd_b_addr == '0) ? '0 : regs_q[rd_b_addr];
`ifdef REGFILE_BYPASS_EN
    if (wr_hit && (wb_addr == rd_a_addr)) rd_a_data = wb_data;
    if (wr_hit && (wb_addr == rd_b_addr)) rd_b_data = wb_data;
`endif
  end

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - operand-fetch stage: regfile read, immediate mux, one-entry ALU output stage
// REGFILE_BYPASS_EN selects write-through of same-cycle writeback into captured operands.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  input  logic [AW-1:0] dest,
  input  logic [15:0]   imm16,
  input  logic          alusrc,
  input  logic [2:0]    ctrl,
  input  logic          flush,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b,
  output logic [2:0]    out_ctrl,
  output logic [AW-1:0] out_dest
);

  logic [DW-1:0] rd_a, rd_b;
  logic          accept;
  operand_t      out_q, out_d;
  logic          out_valid_q, out_valid_d;

  operand_fetch_reg_file u_reg_file (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_a_addr (rs),
    .rd_a_data (rd_a),
    .rd_b_addr (rt),
    .rd_b_data (rd_b),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Data only changes on accept, so a stalled or drained entry keeps its operands.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_d.a     = rd_a;
      out_d.b     = alusrc ? sext16(imm16) : rd_b;
      out_d.ctrl  = ctrl;
      out_d.dest  = dest;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_a     = out_q.a;
  assign out_b     = out_q.b;
  assign out_ctrl  = out_q.ctrl;
  assign out_dest  = out_q.dest;

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - scoreboard bench for operand_fetch (honours REGFILE_BYPASS_EN)
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  logic          clk = 0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [AW-1:0] rs, rt, dest;
  logic [15:0]   imm16;
  logic          alusrc;
  logic [2:0]    ctrl;
  logic          flush;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_a, out_b;
  logic [2:0]    out_ctrl;
  logic [AW-1:0] out_dest;

  int n_tests = 0;
  int n_fail  = 0;

  operand_t      sb_q[$];
  logic [DW-1:0] model_regs [NREG];
  logic          model_valid;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs(rs), .rt(rt), .dest(dest), .imm16(imm16), .alusrc(alusrc), .ctrl(ctrl),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_ctrl(out_ctrl), .out_dest(out_dest)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] idx);
    logic [DW-1:0] v;
    v = (idx == '0) ? '0 : model_regs[idx];
`ifdef REGFILE_BYPASS_EN
    if (wb_en && wb_addr != '0 && wb_addr == idx) v = wb_data;
`endif
    return v;
  endfunction

  // Reference model, evaluated mid-cycle on the inputs the DUT samples at the next edge.
  always @(negedge clk) begin
    operand_t e;
    logic     acc;
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) model_regs[i] = '0;
      model_valid = 1'b0;
      sb_q.delete();
    end else begin
      check("in_ready", {31'd0, in_ready}, {31'd0, !model_valid || out_ready});
      check("out_valid", {31'd0, out_valid}, {31'd0, model_valid});
      if (model_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("sb_a", out_a, e.a);
          check("sb_b", out_b, e.b);
          check("sb_ctrl", {29'd0, out_ctrl}, {29'd0, e.ctrl});
          check("sb_dest", {27'd0, out_dest}, {27'd0, e.dest});
        end
      end else if (model_valid && flush && sb_q.size() != 0) begin
        void'(sb_q.pop_front());
      end
      acc = in_valid && (!model_valid || out_ready) && !flush;
      if (acc) begin
        e.a    = model_read(rs);
        e.b    = alusrc ? {{16{imm16[15]}}, imm16} : model_read(rt);
        e.ctrl = ctrl;
        e.dest = dest;
        sb_q.push_back(e);
        model_valid = 1'b1;
      end else if (flush || out_ready) begin
        model_valid = 1'b0;
      end
      if (wb_en && wb_addr != '0) model_regs[wb_addr] = wb_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; wb_en = 0; flush = 0;
  endtask

  task automatic set_in(input logic [AW-1:0] a_idx, input logic [AW-1:0] b_idx,
                        input logic [AW-1:0] d_idx, input logic [15:0] imm,
                        input logic src, input logic [2:0] op);
    in_valid = 1; rs = a_idx; rt = b_idx; dest = d_idx; imm16 = imm; alusrc = src; ctrl = op;
  endtask

  task automatic set_wb(input logic [AW-1:0] idx, input logic [DW-1:0] data);
    wb_en = 1; wb_addr = idx; wb_data = data;
  endtask

  initial begin
    logic [DW-1:0] saved_a, saved_b;
    rst_n = 0; out_ready = 1;
    idle();
    set_in(0, 0, 0, 0, 0, ALU_ADD);
    in_valid = 0;
    wb_addr = 0; wb_data = 0;
    step(); step();
    rst_n = 1;
    step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_a", out_a, 32'd0);
    check("rst_out_b", out_b, 32'd0);
    check("rst_out_ctrl", {29'd0, out_ctrl}, 32'd0);
    check("rst_out_dest", {27'd0, out_dest}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset clears R5 and overrides a same-cycle write and accept
    set_wb(5, 32'h1234); step(); idle();
    set_in(5, 0, 1, 0, 0, ALU_SUB); step(); idle(); step();
    rst_n = 0; set_in(5, 0, 1, 0, 0, ALU_SUB); set_wb(5, 32'h777); step();
    rst_n = 1; idle(); step();
    check("t1_out_valid", {31'd0, out_valid}, 32'd0);
    set_in(5, 5, 2, 0, 0, ALU_AND); step(); idle();
    check("t1_r5_a", out_a, 32'd0);
    check("t1_r5_b", out_b, 32'd0);

    set_wb(3, 32'hFFFF_FFFE); step(); idle();
    set_in(3, 0, 4, 16'h8001, 1, ALU_ADD); step(); idle();
    check("t2_out_a", out_a, 32'hFFFF_FFFE);
    check("t2_out_b", out_b, 32'hFFFF_8001);
    check("t2_out_valid", {31'd0, out_valid}, 32'd1);

    set_wb(0, 32'hDEAD); step(); idle();
    set_in(0, 0, 5, 16'h0001, 1, ALU_OR); step(); idle();
    check("t3_out_a", out_a, 32'd0);

    set_wb(1, 32'h11); step(); set_wb(2, 32'h22); step(); idle();
    out_ready = 0;
    set_in(1, 2, 6, 0, 0, ALU_OR); step();
    saved_a = out_a; saved_b = out_b;
    set_in(2, 1, 7, 0, 0, ALU_SLT);
    for (int i = 0; i < 3; i++) begin
      check("t4_in_ready_stall", {31'd0, in_ready}, 32'd0);
      check("t4_a_stable", out_a, saved_a);
      check("t4_b_stable", out_b, saved_b);
      step();
    end
    out_ready = 1; #1;
    check("t4_in_ready_release", {31'd0, in_ready}, 32'd1);
    step(); idle();
    check("t4_next_a", out_a, 32'h22);
    check("t4_next_b", out_b, 32'h11);

    set_wb(7, 32'h1); step(); idle();
    set_wb(7, 32'hA5A5_A5A5); set_in(7, 0, 8, 16'h0, 1, ALU_ADD); step(); idle();
`ifdef REGFILE_BYPASS_EN
    check("t5_bypass_a", out_a, 32'hA5A5_A5A5);
`else
    check("t5_nobypass_a", out_a, 32'h1);
`endif

    out_ready = 0;
    set_in(2, 0, 9, 16'h5, 1, ALU_SUB); step(); idle();
    check("t6_pre_valid", {31'd0, out_valid}, 32'd1);
    flush = 1; set_in(1, 0, 10, 0, 0, ALU_ADD); set_wb(9, 32'h99); step(); idle();
    check("t6_flush_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1;
    set_in(9, 9, 11, 0, 0, ALU_AND); step(); idle();
    check("t6_wb_committed", out_a, 32'h99);

    for (int i = 0; i < 80; i++) begin
      set_in(AW'($urandom), AW'($urandom), AW'($urandom), 16'($urandom),
             1'($urandom), 3'($urandom));
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      wb_en     = 1'($urandom);
      wb_addr   = AW'($urandom_range(0, 7));
      wb_data   = $urandom;
      step();
    end
    idle(); out_ready = 1;
    step(); step(); step();
    check("sb_drained", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
